// File: rtl/i2c_pkg.sv
// Shared types and constants for the i2c_dri bit-level I2C master.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_CTRL_W,
      ST_ADDR_H,
      ST_ADDR_L,
      ST_DATA_WR,
      ST_RESTART,
      ST_CTRL_R,
      ST_DATA_RD,
      ST_STOP,
      ST_DONE
   } i2c_state_e;

   localparam logic [1:0] PH_LOW0  = 2'd0;
   localparam logic [1:0] PH_LOW1  = 2'd1;
   localparam logic [1:0] PH_HIGH0 = 2'd2;
   localparam logic [1:0] PH_HIGH1 = 2'd3;

   localparam int BYTE_SLOTS = 9;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   function automatic logic is_byte_state(input i2c_state_e s);
      return (s == ST_CTRL_W) || (s == ST_ADDR_H) || (s == ST_ADDR_L) ||
             (s == ST_DATA_WR) || (s == ST_CTRL_R) || (s == ST_DATA_RD);
   endfunction

   // Bytes whose 9th slot is answered by the slave (DATA_RD's is the master NACK).
   function automatic logic has_slave_ack(input i2c_state_e s);
      return is_byte_state(s) && (s != ST_DATA_RD);
   endfunction

endpackage

// File: rtl/i2c_byte_shift.sv
// 9-slot byte shifter: MSB-first transmit bit plus trailing release slot,
// receive capture for slots 0..7, and a slot counter flagging the ACK slot.
module i2c_byte_shift
   import i2c_pkg::*;
(
   input  logic       clk_i,
   input  logic       srst_i,
   input  logic       load_i,
   input  logic [7:0] load_byte_i,
   input  logic       step_i,
   input  logic       sample_i,
   input  logic       sda_i,
   output logic       tx_next_o,
   output logic       slot_last_o,
   output logic [7:0] rx_byte_o
);

   logic [8:0] shift_q, shift_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] rx_q, rx_d;

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      if (load_i) begin
         shift_d = {load_byte_i, 1'b1};
         cnt_d   = 4'd0;
      end else if (step_i) begin
         shift_d = {shift_q[7:0], 1'b1};
         cnt_d   = cnt_q + 4'd1;
      end
      if (sample_i && (cnt_q < 4'(BYTE_SLOTS - 1))) begin
         rx_d = {rx_q[6:0], sda_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         shift_q <= '1;
         cnt_q   <= '0;
         rx_q    <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         rx_q    <= rx_d;
      end
   end

   // Next-cycle bit so the parent can register SDA in step with its phase.
   assign tx_next_o   = shift_d[8];
   assign slot_last_o = (cnt_q == 4'(BYTE_SLOTS - 1));
   assign rx_byte_o   = rx_q;

endmodule

// File: rtl/i2c_dri.sv
// Bit-level I2C master: single-byte write / random read, 4 dri_clk per SCL bit.
// Define I2C_ACK_ABORT_EN to jump to STOP on any slave NACK.
module i2c_dri
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'b1010000
) (
   input  logic        dri_clk,
   input  logic        rst,
   input  logic        i2c_exec,
   input  logic        bit_ctrl,
   input  logic        i2c_rh_wl,
   input  logic [15:0] i2c_addr,
   input  logic [7:0]  i2c_data_w,
   output logic [7:0]  i2c_data_r,
   output logic        i2c_done,
   output logic        i2c_ack,
   output logic        scl,
   input  logic        sda_in,
   output logic        sda_oe
);

   i2c_state_e  state_q, state_d;
   logic [1:0]  phase_q, phase_d;
   logic        bit_ctrl_q, rh_wl_q;
   logic [15:0] addr_q;
   logic [7:0]  data_w_q;
   logic        ack_q;
   logic [7:0]  data_r_q;
   logic        done_q, scl_q, sda_oe_q;
   logic        scl_d, sda_oe_d;

   logic        slot_end, abort_nack;
   logic        shift_load, shift_step, shift_sample;
   logic [7:0]  load_byte, rx_byte;
   logic        tx_next, slot_last;

   assign slot_end = (phase_q == PH_HIGH1);

`ifdef I2C_ACK_ABORT_EN
   assign abort_nack = ack_q;
`else
   assign abort_nack = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      phase_d = phase_q + 2'd1;
      case (state_q)
         ST_IDLE: begin
            phase_d = PH_LOW0;
            if (i2c_exec) state_d = ST_START;
         end
         ST_START:   if (slot_end) state_d = ST_CTRL_W;
         ST_CTRL_W:  if (slot_end && slot_last) state_d = bit_ctrl_q ? ST_ADDR_H : ST_ADDR_L;
         ST_ADDR_H:  if (slot_end && slot_last) state_d = ST_ADDR_L;
         ST_ADDR_L:  if (slot_end && slot_last) state_d = rh_wl_q ? ST_RESTART : ST_DATA_WR;
         ST_DATA_WR: if (slot_end && slot_last) state_d = ST_STOP;
         ST_RESTART: if (slot_end) state_d = ST_CTRL_R;
         ST_CTRL_R:  if (slot_end && slot_last) state_d = ST_DATA_RD;
         ST_DATA_RD: if (slot_end && slot_last) state_d = ST_STOP;
         ST_STOP:    if (slot_end) state_d = ST_DONE;
         ST_DONE: begin
            phase_d = PH_LOW0;
            state_d = ST_IDLE;
         end
         default: begin
            phase_d = PH_LOW0;
            state_d = ST_IDLE;
         end
      endcase
      if (has_slave_ack(state_q) && slot_end && slot_last && abort_nack) begin
         state_d = ST_STOP;
      end
   end

   always_comb begin
      case (state_d)
         ST_CTRL_W:  load_byte = {SLAVE_ADDR, RW_WRITE};
         ST_ADDR_H:  load_byte = addr_q[15:8];
         ST_ADDR_L:  load_byte = addr_q[7:0];
         ST_DATA_WR: load_byte = data_w_q;
         ST_CTRL_R:  load_byte = {SLAVE_ADDR, RW_READ};
         default:    load_byte = 8'hFF;
      endcase
   end

   assign shift_load   = slot_end && is_byte_state(state_d) && (state_d != state_q);
   assign shift_step   = slot_end && is_byte_state(state_q) && !slot_last;
   assign shift_sample = (phase_q == PH_HIGH0) && (state_q == ST_DATA_RD);

   i2c_byte_shift u_shift (
      .clk_i       (dri_clk),
      .srst_i      (rst),
      .load_i      (shift_load),
      .load_byte_i (load_byte),
      .step_i      (shift_step),
      .sample_i    (shift_sample),
      .sda_i       (sda_in),
      .tx_next_o   (tx_next),
      .slot_last_o (slot_last),
      .rx_byte_o   (rx_byte)
   );

   // Pin levels are computed for the upcoming phase so the registers line up with it.
   always_comb begin
      scl_d    = 1'b1;
      sda_oe_d = 1'b0;
      case (state_d)
         ST_START: sda_oe_d = phase_d[1];
         ST_RESTART: begin
            scl_d    = (phase_d != PH_LOW0);
            sda_oe_d = phase_d[1];
         end
         ST_STOP: begin
            scl_d    = phase_d[1];
            sda_oe_d = (phase_d != PH_HIGH1);
         end
         default: begin
            if (is_byte_state(state_d)) begin
               scl_d    = !((phase_d == PH_LOW0) || (phase_d == PH_LOW1));
               sda_oe_d = !tx_next;
            end
         end
      endcase
   end

   always_ff @(posedge dri_clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         phase_q    <= PH_LOW0;
         bit_ctrl_q <= 1'b0;
         rh_wl_q    <= 1'b0;
         addr_q     <= '0;
         data_w_q   <= '0;
         ack_q      <= 1'b0;
         data_r_q   <= '0;
         done_q     <= 1'b0;
         scl_q      <= 1'b1;
         sda_oe_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         scl_q    <= scl_d;
         sda_oe_q <= sda_oe_d;
         done_q   <= (state_d == ST_DONE);
         if ((state_q == ST_IDLE) && i2c_exec) begin
            bit_ctrl_q <= bit_ctrl;
            rh_wl_q    <= i2c_rh_wl;
            addr_q     <= i2c_addr;
            data_w_q   <= i2c_data_w;
            ack_q      <= 1'b0;
         end
         if (has_slave_ack(state_q) && slot_last && (phase_q == PH_HIGH0) && sda_in) begin
            ack_q <= 1'b1;
         end
         if ((state_d == ST_DONE) && rh_wl_q && !abort_nack) begin
            data_r_q <= rx_byte;
         end
      end
   end

   assign i2c_data_r = data_r_q;
   assign i2c_done   = done_q;
   assign i2c_ack    = ack_q;
   assign scl        = scl_q;
   assign sda_oe     = sda_oe_q;

endmodule

// File: tb/tb_i2c_dri.sv
// Directed bench for i2c_dri with a bus-level slave model that logs bytes,
// ACKs (or NACKs a chosen byte) and returns a read byte.
module tb_i2c_dri;

   logic        dri_clk = 1'b0;
   logic        rst = 1'b1;
   logic        i2c_exec = 1'b0;
   logic        bit_ctrl = 1'b0;
   logic        i2c_rh_wl = 1'b0;
   logic [15:0] i2c_addr = '0;
   logic [7:0]  i2c_data_w = '0;
   logic [7:0]  i2c_data_r;
   logic        i2c_done, i2c_ack, scl, sda_oe;
   logic        sda_in;

   int checks = 0;
   int errors = 0;

   // slave model state
   logic       slave_low = 1'b0;
   logic       prev_scl = 1'b1, prev_sda = 1'b1;
   logic       slave_tx = 1'b0, acked = 1'b0, mack = 1'b0;
   logic [7:0] rx_sr = '0, last_rx = '0, rd_byte = 8'h3C;
   int         bitc = 0, frame_bytes = 0, nack_idx = -1, starts = 0, stops = 0;
   logic [7:0] log_q[$];

   i2c_dri dut (
      .dri_clk    (dri_clk),
      .rst        (rst),
      .i2c_exec   (i2c_exec),
      .bit_ctrl   (bit_ctrl),
      .i2c_rh_wl  (i2c_rh_wl),
      .i2c_addr   (i2c_addr),
      .i2c_data_w (i2c_data_w),
      .i2c_data_r (i2c_data_r),
      .i2c_done   (i2c_done),
      .i2c_ack    (i2c_ack),
      .scl        (scl),
      .sda_in     (sda_in),
      .sda_oe     (sda_oe)
   );

   always #5 dri_clk = ~dri_clk;

   assign sda_in = ~(sda_oe | slave_low);

   // Slave watches the bus on the falling dri_clk edge, away from the DUT's edge.
   always @(negedge dri_clk) begin
      if (rst) begin
         bitc      <= 0;
         slave_low <= 1'b0;
         slave_tx  <= 1'b0;
         prev_scl  <= 1'b1;
         prev_sda  <= 1'b1;
      end else begin
         prev_scl <= scl;
         prev_sda <= sda_in;
         if (prev_scl && scl && prev_sda && !sda_in) begin
            starts      <= starts + 1;
            bitc        <= 0;
            frame_bytes <= 0;
            slave_tx    <= 1'b0;
         end else if (prev_scl && scl && !prev_sda && sda_in) begin
            stops    <= stops + 1;
            bitc     <= 0;
            slave_tx <= 1'b0;
         end else if (!prev_scl && scl) begin
            if (slave_tx && bitc == 8) mack <= sda_in;
            if (!slave_tx && bitc < 8) rx_sr <= {rx_sr[6:0], sda_in};
            bitc <= bitc + 1;
         end else if (prev_scl && !scl) begin
            if (bitc == 8) begin
               if (slave_tx) begin
                  slave_low <= 1'b0;
               end else begin
                  acked       <= (log_q.size() != nack_idx);
                  slave_low   <= (log_q.size() != nack_idx);
                  last_rx     <= rx_sr;
                  frame_bytes <= frame_bytes + 1;
                  log_q.push_back(rx_sr);
               end
            end else if (bitc == 9) begin
               bitc <= 0;
               if (!slave_tx && acked && frame_bytes == 1 && last_rx[0]) begin
                  slave_tx  <= 1'b1;
                  slave_low <= !rd_byte[7];
               end else begin
                  slave_tx  <= 1'b0;
                  slave_low <= 1'b0;
               end
            end else if (slave_tx && bitc >= 1 && bitc <= 7) begin
               slave_low <= !rd_byte[7 - bitc];
            end
         end
      end
   end

   task automatic clear_slave();
      log_q.delete();
      nack_idx = -1;
      mack = 1'b0;
   endtask

   task automatic do_txn(input logic rw, input logic bc, input logic [15:0] a,
                         input logic [7:0] d, output int lat);
      @(posedge dri_clk); #1;
      i2c_rh_wl = rw; bit_ctrl = bc; i2c_addr = a; i2c_data_w = d; i2c_exec = 1'b1;
      @(posedge dri_clk); #1;
      i2c_exec = 1'b0;
      lat = -1;
      for (int n = 1; n <= 400; n++) begin
         @(posedge dri_clk); #1;
         if (i2c_done) begin
            lat = n;
            break;
         end
      end
      $display("txn rw=%0d bc=%0d addr=%h data_w=%h lat=%0d ack=%0d data_r=%h bytes=%0d",
               rw, bc, a, d, lat, i2c_ack, i2c_data_r, log_q.size());
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge dri_clk);
      #1;
      checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl got=%b exp=1", scl); end
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
      checks++; if (i2c_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", i2c_done); end
      checks++; if (i2c_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", i2c_ack); end
      checks++; if (i2c_data_r !== 8'h00) begin errors++; $display("FAIL reset_data_r got=%h exp=00", i2c_data_r); end
      rst = 1'b0;
      $display("txn reset done");
   endtask

   task automatic test_write16();
      int lat;
      logic [7:0] exp_b [4];
      logic [7:0] got;
      exp_b = '{8'hA0, 8'h00, 8'h12, 8'hA5};
      clear_slave();
      do_txn(1'b0, 1'b1, 16'h0012, 8'hA5, lat);
      checks++; if (lat !== 152) begin errors++; $display("FAIL w16_latency got=%0d exp=152", lat); end
      checks++; if (i2c_ack !== 1'b0) begin errors++; $display("FAIL w16_ack got=%b exp=0", i2c_ack); end
      checks++; if (log_q.size() !== 4) begin errors++; $display("FAIL w16_nbytes got=%0d exp=4", log_q.size()); end
      for (int i = 0; i < 4; i++) begin
         got = (i < log_q.size()) ? log_q[i] : 8'hxx;
         checks++; if (got !== exp_b[i]) begin errors++; $display("FAIL w16_byte%0d got=%h exp=%h", i, got, exp_b[i]); end
      end
   endtask

   task automatic test_read16();
      int lat, s0;
      logic [7:0] exp_b [4];
      logic [7:0] got;
      exp_b = '{8'hA0, 8'h00, 8'h12, 8'hA1};
      clear_slave();
      rd_byte = 8'h3C;
      s0 = starts;
      do_txn(1'b1, 1'b1, 16'h0012, 8'h00, lat);
      checks++; if (lat !== 192) begin errors++; $display("FAIL r16_latency got=%0d exp=192", lat); end
      checks++; if (i2c_data_r !== 8'h3C) begin errors++; $display("FAIL r16_data got=%h exp=3C", i2c_data_r); end
      checks++; if (i2c_ack !== 1'b0) begin errors++; $display("FAIL r16_ack got=%b exp=0", i2c_ack); end
      checks++; if (mack !== 1'b1) begin errors++; $display("FAIL r16_master_nack got=%b exp=1", mack); end
      checks++; if (starts - s0 !== 2) begin errors++; $display("FAIL r16_starts got=%0d exp=2", starts - s0); end
      for (int i = 0; i < 4; i++) begin
         got = (i < log_q.size()) ? log_q[i] : 8'hxx;
         checks++; if (got !== exp_b[i]) begin errors++; $display("FAIL r16_byte%0d got=%h exp=%h", i, got, exp_b[i]); end
      end
   endtask

   task automatic test_write8();
      int lat;
      logic [7:0] exp_b [3];
      logic [7:0] got;
      exp_b = '{8'hA0, 8'h34, 8'h5A};
      clear_slave();
      do_txn(1'b0, 1'b0, 16'h0034, 8'h5A, lat);
      checks++; if (lat !== 116) begin errors++; $display("FAIL w8_latency got=%0d exp=116", lat); end
      checks++; if (log_q.size() !== 3) begin errors++; $display("FAIL w8_nbytes got=%0d exp=3", log_q.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < log_q.size()) ? log_q[i] : 8'hxx;
         checks++; if (got !== exp_b[i]) begin errors++; $display("FAIL w8_byte%0d got=%h exp=%h", i, got, exp_b[i]); end
      end
      checks++; if (i2c_data_r !== 8'h3C) begin errors++; $display("FAIL w8_data_r_kept got=%h exp=3C", i2c_data_r); end
   endtask

   task automatic test_nack();
      int lat, exp_lat, exp_n, s0;
`ifdef I2C_ACK_ABORT_EN
      exp_lat = 116;
      exp_n   = 3;
`else
      exp_lat = 152;
      exp_n   = 4;
`endif
      clear_slave();
      nack_idx = 2;
      s0 = stops;
      do_txn(1'b0, 1'b1, 16'h0012, 8'hA5, lat);
      checks++; if (i2c_ack !== 1'b1) begin errors++; $display("FAIL nack_ack got=%b exp=1", i2c_ack); end
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL nack_latency got=%0d exp=%0d", lat, exp_lat); end
      checks++; if (log_q.size() !== exp_n) begin errors++; $display("FAIL nack_nbytes got=%0d exp=%0d", log_q.size(), exp_n); end
      checks++; if (stops - s0 !== 1) begin errors++; $display("FAIL nack_stops got=%0d exp=1", stops - s0); end
   endtask

   task automatic test_busy_exec();
      int n_done, lat, s0;
      n_done = 0;
      lat = -1;
      clear_slave();
      s0 = starts;
      @(posedge dri_clk); #1;
      i2c_rh_wl = 1'b0; bit_ctrl = 1'b1; i2c_addr = 16'h0012; i2c_data_w = 8'hA5; i2c_exec = 1'b1;
      @(posedge dri_clk); #1;
      i2c_exec = 1'b0;
      for (int n = 1; n <= 300; n++) begin
         @(posedge dri_clk); #1;
         if (i2c_done) begin
            n_done++;
            if (lat < 0) lat = n;
         end
         i2c_exec = (n == 50);
      end
      i2c_exec = 1'b0;
      $display("txn busy-exec lat=%0d dones=%0d ack=%0d", lat, n_done, i2c_ack);
      checks++; if (n_done !== 1) begin errors++; $display("FAIL busy_done_count got=%0d exp=1", n_done); end
      checks++; if (lat !== 152) begin errors++; $display("FAIL busy_latency got=%0d exp=152", lat); end
      checks++; if (i2c_ack !== 1'b0) begin errors++; $display("FAIL busy_ack_cleared got=%b exp=0", i2c_ack); end
      checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL busy_starts got=%0d exp=1", starts - s0); end
   endtask

   task automatic test_reset_mid();
      int lat;
      clear_slave();
      @(posedge dri_clk); #1;
      i2c_rh_wl = 1'b0; bit_ctrl = 1'b1; i2c_addr = 16'h0012; i2c_data_w = 8'hA5; i2c_exec = 1'b1;
      @(posedge dri_clk); #1;
      i2c_exec = 1'b0;
      repeat (120) @(posedge dri_clk);
      #1;
      rst = 1'b1;
      @(posedge dri_clk); #1;
      rst = 1'b0;
      $display("txn reset mid DATA_WR");
      checks++; if (scl !== 1'b1) begin errors++; $display("FAIL midrst_scl got=%b exp=1", scl); end
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL midrst_sda_oe got=%b exp=0", sda_oe); end
      checks++; if (i2c_done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", i2c_done); end
      checks++; if (i2c_data_r !== 8'h00) begin errors++; $display("FAIL midrst_data_r got=%h exp=00", i2c_data_r); end
      clear_slave();
      do_txn(1'b0, 1'b0, 16'h0034, 8'h5A, lat);
      checks++; if (lat !== 116) begin errors++; $display("FAIL midrst_next_latency got=%0d exp=116", lat); end
      checks++; if (log_q.size() !== 3) begin errors++; $display("FAIL midrst_next_nbytes got=%0d exp=3", log_q.size()); end
   endtask

   task automatic test_back_to_back();
      int lat, s0, n_done;
      logic [7:0] got;
      // exec held across the DONE cycle and the following IDLE cycle: only the second counts
      clear_slave();
      i2c_rh_wl = 1'b0; bit_ctrl = 1'b0; i2c_addr = 16'h0056; i2c_data_w = 8'h11; i2c_exec = 1'b1;
      @(posedge dri_clk); #1;
      @(posedge dri_clk); #1;
      i2c_exec = 1'b0;
      lat = -1;
      for (int n = 1; n <= 400; n++) begin
         @(posedge dri_clk); #1;
         if (i2c_done) begin
            lat = n;
            break;
         end
      end
      $display("txn back-to-back lat=%0d ack=%0d bytes=%0d", lat, i2c_ack, log_q.size());
      checks++; if (lat !== 116) begin errors++; $display("FAIL b2b_latency got=%0d exp=116", lat); end
      got = (log_q.size() > 1) ? log_q[1] : 8'hxx;
      checks++; if (got !== 8'h56) begin errors++; $display("FAIL b2b_addr_byte got=%h exp=56", got); end
      // a single exec pulse landing in DONE is dropped
      s0 = starts;
      n_done = 0;
      i2c_exec = 1'b1;
      @(posedge dri_clk); #1;
      i2c_exec = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         @(posedge dri_clk); #1;
         if (i2c_done) n_done++;
      end
      $display("txn exec-in-DONE dones=%0d starts=%0d", n_done, starts - s0);
      checks++; if (n_done !== 0) begin errors++; $display("FAIL done_exec_dropped got=%0d exp=0", n_done); end
      checks++; if (starts - s0 !== 0) begin errors++; $display("FAIL done_exec_starts got=%0d exp=0", starts - s0); end
      checks++; if (scl !== 1'b1) begin errors++; $display("FAIL idle_scl got=%b exp=1", scl); end
   endtask

   initial begin
      test_reset();
      test_write16();
      test_read16();
      test_write8();
      test_nack();
      test_busy_exec();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
